// File: rtl/button_int_ctrl.sv
// button_int_ctrl: synchronises, debounces and edge-detects four active-low
// pushbuttons, latches presses as pending and issues them one at a time as
// single-cycle one-hot interrupt requests while the CPU is outside its ISR.
// Ports: clk, rst_n (async, active low), key_n[3:0] (raw keys, active low),
//   int_state (CPU in ISR), buttons_pressed[3:0] (one-hot request pulse),
//   pending[3:0] (latched, not yet issued), busy (FSM not idle).
// Optional feature macro: BUTTON_AUTOREPEAT_EN (autorepeat of held key).
module button_int_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 12500000,
    parameter int ACK_TIMEOUT     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    input  logic       int_state,
    output logic [3:0] buttons_pressed,
    output logic [3:0] pending,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [23:0] REP_LAST = 24'(REPEAT_CYCLES - 1);

    // Highest set bit as one-hot; bit 3 wins.
    function automatic logic [3:0] top_bit(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = 4'b0001 << i;
        end
        return r;
    endfunction

    logic [3:0]  sync_q1;
    logic [3:0]  sync_q2;
    logic [3:0]  deb;
    logic [3:0]  deb_d;
    logic [15:0] deb_cnt [4];
    logic [3:0]  press;
    logic [3:0] rep_set;

    state_t      state;
    state_t      state_nx;
    logic [15:0] ack_cnt;
    logic [15:0] ack_cnt_nx;
    logic [3:0]  grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= ~key_n;
            sync_q2 <= sync_q1;
        end
    end

    // The counter restarts on every agreement, so only an unbroken run of
    // DEBOUNCE_CYCLES disagreeing samples flips the debounced state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync_q2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync_q2[i];
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != 16'hFFFF) begin
                    deb_cnt[i] <= deb_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign press = deb & ~deb_d;

`ifdef BUTTON_AUTOREPEAT_EN
    logic [23:0] rep_cnt;
    logic        rep_run;

    assign rep_run = (deb == deb_d) && (deb != 4'b0);
    assign rep_set = (rep_run && rep_cnt == REP_LAST) ? top_bit(deb) : 4'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (!rep_run || rep_cnt == REP_LAST) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 24'd1;
        end
    end
`else
    logic unused_rep_cfg;

    assign unused_rep_cfg = ^REP_LAST;
    assign rep_set        = 4'b0;
`endif

    always_comb begin
        state_nx   = state;
        ack_cnt_nx = ack_cnt;
        grant      = 4'b0;
        unique case (state)
            IDLE: begin
                if (pending != 4'b0 && !int_state) begin
                    grant    = top_bit(pending);
                    state_nx = FIRE;
                end
            end
            FIRE: begin
                ack_cnt_nx = '0;
                state_nx   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (int_state) begin
                    state_nx = WAIT_DONE;
                end else if (ack_cnt == ACK_LAST) begin
                    state_nx = IDLE;
                end else begin
                    ack_cnt_nx = ack_cnt + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!int_state) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The granted bit is cleared as its pulse is registered; a new press
    // of the same bit in that cycle still wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ack_cnt         <= '0;
            buttons_pressed <= '0;
            pending         <= '0;
        end else begin
            state           <= state_nx;
            ack_cnt         <= ack_cnt_nx;
            buttons_pressed <= grant;
            pending         <= (pending & ~grant) | press | rep_set;
        end
    end

    assign busy = (state != IDLE);

endmodule
